bias_ctrl: RTL

Sequencer for the LSTM bias stage. On a `start` pulse it walks all gates × neurons of one time step and prefetches bias words from the bias memory through a 2-entry buffer. It pairs each word with an accumulator result arriving over a valid/ready handshake and drives the add-enable, bias operand and index tags into the `bias` datapath. It sits between the matrix-product accumulator and the activation stage, and owns the bias memory read port.

---
 rtl/lstm_pkg.sv | 35 +++
 rtl/bias_fifo2.sv | 58 +++++
 rtl/bias_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// ============================================================================
// lstm_pkg : shared LSTM widths, gate encoding and saturating adder
// Revision : 1.0
// ============================================================================
`default_nettype none

package lstm_pkg;

   localparam int NGATE  = 4;
   localparam int DWIDTH = 16;
   localparam int FBITS  = 8;

   typedef enum logic [1:0] {
      GATE_I = 2'd0,
      GATE_F = 2'd1,
      GATE_O = 2'd2,
      GATE_G = 2'd3
   } gate_e;

   // Signed add clamped to the DWIDTH two's-complement range.
   function automatic logic signed [DWIDTH-1:0] sat_add(
      input logic signed [DWIDTH-1:0] a,
      input logic signed [DWIDTH-1:0] b
   );
      logic signed [DWIDTH:0] s;
      s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
      if (s[DWIDTH] != s[DWIDTH-1])
         sat_add = s[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
      else
         sat_add = s[DWIDTH-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/bias_fifo2.sv
// ============================================================================
// bias_fifo2 : two-entry FIFO with occupancy count for prefetched bias words
// Revision   : 1.0
// ============================================================================
`default_nettype none

module bias_fifo2 #(
   parameter int DWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr,
   input  logic [DWIDTH-1:0] i_wdata,
   input  logic              i_rd,
   output logic [DWIDTH-1:0] o_rdata,
   output logic [1:0]        o_count,
   output logic              o_empty
);

   logic [DWIDTH-1:0] r_mem [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;
   logic              w_do_wr;
   logic              w_do_rd;

   assign w_do_wr = i_wr & (r_count != 2'd2);
   assign w_do_rd = i_rd & (r_count != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_wr) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= ~r_wptr;
         end
         if (w_do_rd)
            r_rptr <= ~r_rptr;
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_empty = (r_count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/bias_ctrl.sv
// ============================================================================
// bias_ctrl : LSTM bias-stage sequencer; prefetches bias words and pairs them
//             with accumulator results. Option macro: BIAS_CTRL_FORGET_ONE_EN
// Revision  : 1.0
// ============================================================================
`default_nettype none

module bias_ctrl #(
   parameter int DWIDTH    = lstm_pkg::DWIDTH,
   parameter int FBITS     = lstm_pkg::FBITS,
   parameter int NGATE     = lstm_pkg::NGATE,
   parameter int MAXNEURON = 256,
   parameter int ADDRW     = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(MAXNEURON):0]   n_neuron,
   input  logic [ADDRW-1:0]             base,
   output logic                         busy,
   output logic                         done,
   output logic                         mem_re,
   output logic [ADDRW-1:0]             mem_addr,
   input  logic [DWIDTH-1:0]            mem_rdata,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         bias_en,
   output logic [DWIDTH-1:0]            bias_data,
   output logic [1:0]                   gate_idx,
   output logic [$clog2(MAXNEURON)-1:0] neuron_idx,
   output logic                         last
);

   import lstm_pkg::*;

   localparam int IW = $clog2(MAXNEURON);
   localparam int NW = IW + 1;
   localparam int CW = NW + $clog2(NGATE);
   localparam logic [DWIDTH-1:0] c_ONE = DWIDTH'(1) << FBITS;
`ifdef BIAS_CTRL_FORGET_ONE_EN
   localparam logic c_FORGET_ONE = 1'b1;
`else
   localparam logic c_FORGET_ONE = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            r_state;
   state_e            w_next;
   logic [NW-1:0]     r_nlat;
   logic [ADDRW-1:0]  r_base;
   logic [CW-1:0]     r_issued;
   logic [1:0]        r_iss_gate;
   logic [IW-1:0]     r_iss_nrn;
   logic              r_inflight;
   logic [1:0]        r_rd_gate;
   logic [1:0]        r_gate;
   logic [IW-1:0]     r_nrn;

   logic              w_run;
   logic [CW-1:0]     w_total;
   logic [NW-1:0]     w_nmax;
   logic              w_nrn_wrap;
   logic              w_iss_wrap;
   logic [1:0]        w_count;
   logic              w_empty;
   logic [DWIDTH-1:0] w_head;
   logic [DWIDTH-1:0] w_fix;
   logic [DWIDTH-1:0] w_wdata;
   logic [2:0]        w_occ;

   assign w_run      = (r_state == S_RUN);
   assign w_total    = CW'(r_nlat) * CW'(NGATE);
   assign w_nmax     = r_nlat - NW'(1);
   assign w_nrn_wrap = (r_nrn == w_nmax[IW-1:0]);
   assign w_iss_wrap = (r_iss_nrn == w_nmax[IW-1:0]);

   // Credit: words buffered plus the word returning next edge, less the pop.
   assign w_occ    = {1'b0, w_count} + {2'b00, r_inflight};
   assign mem_re   = w_run && (r_issued < w_total) && (w_occ < (3'd2 + {2'b00, bias_en}));
   assign mem_addr = r_base + ADDRW'(r_issued);

   assign in_ready   = w_run & ~w_empty;
   assign bias_en    = in_valid & in_ready;
   assign bias_data  = w_head;
   assign gate_idx   = r_gate;
   assign neuron_idx = r_nrn;
   assign last       = w_run & (r_gate == 2'(NGATE - 1)) & w_nrn_wrap;
   assign busy       = (r_state == S_RUN) | (r_state == S_DONE);
   assign done       = (r_state == S_DONE);

   assign w_fix   = sat_add(mem_rdata, c_ONE);
   assign w_wdata = (c_FORGET_ONE && (r_rd_gate == GATE_F)) ? w_fix : mem_rdata;

   bias_fifo2 #(
      .DWIDTH (DWIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (r_inflight),
      .i_wdata (w_wdata),
      .i_rd    (bias_en),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (bias_en && last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_nlat     <= '0;
         r_base     <= '0;
         r_issued   <= '0;
         r_iss_gate <= '0;
         r_iss_nrn  <= '0;
         r_inflight <= 1'b0;
         r_rd_gate  <= '0;
         r_gate     <= '0;
         r_nrn      <= '0;
      end else begin
         r_state    <= w_next;
         r_inflight <= mem_re;
         if ((r_state == S_IDLE) && start) begin
            r_base     <= base;
            r_nlat     <= (n_neuron == '0) ? NW'(1) : n_neuron;
            r_issued   <= '0;
            r_iss_gate <= '0;
            r_iss_nrn  <= '0;
            r_gate     <= '0;
            r_nrn      <= '0;
         end
         if (mem_re) begin
            r_issued  <= r_issued + CW'(1);
            r_rd_gate <= r_iss_gate;
            if (w_iss_wrap) begin
               r_iss_nrn  <= '0;
               r_iss_gate <= r_iss_gate + 2'd1;
            end else begin
               r_iss_nrn  <= r_iss_nrn + IW'(1);
            end
         end
         if (bias_en) begin
            if (w_nrn_wrap) begin
               r_nrn  <= '0;
               r_gate <= r_gate + 2'd1;
            end else begin
               r_nrn  <= r_nrn + IW'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire
